// File: rtl/rob_pkg.sv
// rtl/rob_pkg.sv - shared reorder buffer widths and entry layout
package rob_pkg;
  localparam int TAG_W  = 5;
  localparam int DEPTH  = 1 << TAG_W;
  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  typedef struct packed {
    logic              busy;
    logic              done;
    logic              has_dest;
    logic              is_branch;
    logic              mispredict;
    logic [REG_W-1:0]  dest;
    logic [DATA_W-1:0] data;
  } rob_entry_t;
endpackage

// File: rtl/rob.sv
// rtl/rob.sv - reorder buffer: tag allocation, CDB writeback, in-order commit, flush
module rob
  import rob_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              disp_valid,
  input  logic              disp_has_dest,
  input  logic [REG_W-1:0]  disp_dest,
  input  logic              disp_is_branch,
  output logic              disp_ready,
  output logic [TAG_W-1:0]  disp_tag,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  input  logic              cdb_mispredict,
  input  logic [TAG_W-1:0]  rd_tag,
  output logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              commit_valid,
  output logic [TAG_W-1:0]  commit_tag,
  output logic              commit_wen,
  output logic [REG_W-1:0]  commit_dest,
  output logic [DATA_W-1:0] commit_data,
  output logic              flush,
  output logic [TAG_W:0]    count
);

  rob_entry_t       entries [DEPTH];
  rob_entry_t       head_e;
  rob_entry_t       rd_e;
  rob_entry_t       new_e;
  logic [TAG_W-1:0] head;
  logic [TAG_W-1:0] tail;
  logic [TAG_W:0]   count_q;
  logic             disp_fire;

  assign head_e       = entries[head];
  assign rd_e         = entries[rd_tag];

  assign disp_ready   = (count_q != (TAG_W+1)'(DEPTH));
  assign disp_tag     = tail;
  assign disp_fire    = disp_valid & disp_ready;

  assign commit_valid = head_e.busy & head_e.done;
  assign commit_tag   = head;
  assign commit_wen   = commit_valid & head_e.has_dest;
  assign commit_dest  = head_e.dest;
  assign commit_data  = head_e.data;
  assign flush        = commit_valid & head_e.is_branch & head_e.mispredict;

  assign rd_ready     = rd_e.busy & rd_e.done;
  assign rd_data      = rd_e.data;
  assign count        = count_q;

  always_comb begin
    new_e            = '0;
    new_e.busy       = 1'b1;
    new_e.has_dest   = disp_has_dest;
    new_e.is_branch  = disp_is_branch;
    new_e.dest       = disp_dest;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else if (flush) begin
      // The mispredicted branch retires; everything younger is squashed,
      // including anything dispatched this same cycle.
      for (int i = 0; i < DEPTH; i++) entries[i].busy <= 1'b0;
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else begin
      if (cdb_valid && entries[cdb_tag].busy) begin
        entries[cdb_tag].done       <= 1'b1;
        entries[cdb_tag].data       <= cdb_data;
        entries[cdb_tag].mispredict <= cdb_mispredict;
      end
      if (commit_valid) begin
        entries[head].busy <= 1'b0;
        head               <= head + 1'b1;
      end
      // tail can only equal head here when empty, so this never collides with a commit
      if (disp_fire) begin
        entries[tail] <= new_e;
        tail          <= tail + 1'b1;
      end
      count_q <= count_q + (TAG_W+1)'(disp_fire) - (TAG_W+1)'(commit_valid);
    end
  end

endmodule

// File: tb/tb_rob.sv
// tb/tb_rob.sv - scoreboard bench for the reorder buffer
module tb_rob;
  import rob_pkg::*;

  logic              clock = 1'b0;
  logic              reset;
  logic              disp_valid;
  logic              disp_has_dest;
  logic [REG_W-1:0]  disp_dest;
  logic              disp_is_branch;
  logic              disp_ready;
  logic [TAG_W-1:0]  disp_tag;
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;
  logic              cdb_mispredict;
  logic [TAG_W-1:0]  rd_tag;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic              commit_valid;
  logic [TAG_W-1:0]  commit_tag;
  logic              commit_wen;
  logic [REG_W-1:0]  commit_dest;
  logic [DATA_W-1:0] commit_data;
  logic              flush;
  logic [TAG_W:0]    count;

  typedef struct {
    logic [TAG_W-1:0]  tag;
    logic              wen;
    logic [REG_W-1:0]  dest;
    logic [DATA_W-1:0] data;
    logic              flush;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;

  rob dut (
    .clock(clock), .reset(reset),
    .disp_valid(disp_valid), .disp_has_dest(disp_has_dest), .disp_dest(disp_dest),
    .disp_is_branch(disp_is_branch), .disp_ready(disp_ready), .disp_tag(disp_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .cdb_mispredict(cdb_mispredict), .rd_tag(rd_tag), .rd_ready(rd_ready), .rd_data(rd_data),
    .commit_valid(commit_valid), .commit_tag(commit_tag), .commit_wen(commit_wen),
    .commit_dest(commit_dest), .commit_data(commit_data), .flush(flush), .count(count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: every retirement must match the next expected commit
  always @(negedge clock) begin
    if (!reset && commit_valid) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_commit actual tag=%0d required no commit", commit_tag);
      end else begin
        mon_e = sb.pop_front();
        chk("commit_tag",  64'(commit_tag),  64'(mon_e.tag));
        chk("commit_wen",  64'(commit_wen),  64'(mon_e.wen));
        chk("commit_dest", 64'(commit_dest), 64'(mon_e.dest));
        chk("commit_data", 64'(commit_data), 64'(mon_e.data));
        chk("commit_flush", 64'(flush),      64'(mon_e.flush));
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input int tag, input logic wen, input int dest, input int data, input logic fl);
    exp_t e;
    e.tag = TAG_W'(tag); e.wen = wen; e.dest = REG_W'(dest); e.data = DATA_W'(data); e.flush = fl;
    sb.push_back(e);
  endtask

  task automatic dispatch(input logic has_dest, input int dest, input logic is_br);
    disp_valid = 1'b1; disp_has_dest = has_dest; disp_dest = REG_W'(dest); disp_is_branch = is_br;
    tick();
    disp_valid = 1'b0; disp_has_dest = 1'b0; disp_dest = '0; disp_is_branch = 1'b0;
  endtask

  task automatic cdb(input int tag, input int data, input logic mp);
    cdb_valid = 1'b1; cdb_tag = TAG_W'(tag); cdb_data = DATA_W'(data); cdb_mispredict = mp;
    tick();
    cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0; cdb_mispredict = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    disp_valid = 1'b0; disp_has_dest = 1'b0; disp_dest = '0; disp_is_branch = 1'b0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0; cdb_mispredict = 1'b0; rd_tag = '0;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    chk("rst_count",        64'(count),        64'd0);
    chk("rst_disp_ready",   64'(disp_ready),   64'd1);
    chk("rst_disp_tag",     64'(disp_tag),     64'd0);
    chk("rst_commit_valid", 64'(commit_valid), 64'd0);
    chk("rst_commit_wen",   64'(commit_wen),   64'd0);
    chk("rst_commit_tag",   64'(commit_tag),   64'd0);
    chk("rst_commit_dest",  64'(commit_dest),  64'd0);
    chk("rst_commit_data",  64'(commit_data),  64'd0);
    chk("rst_flush",        64'(flush),        64'd0);
    chk("rst_rd_ready",     64'(rd_ready),     64'd0);
    chk("rst_rd_data",      64'(rd_data),      64'd0);

    // In-order retirement of out-of-order completions
    push(0, 1'b1, 1, 32'h10, 1'b0);
    push(1, 1'b1, 2, 32'h11, 1'b0);
    push(2, 1'b1, 3, 32'h12, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("alloc_tag", 64'(disp_tag), 64'(i));
      dispatch(1'b1, i + 1, 1'b0);
    end
    chk("count_3", 64'(count), 64'd3);
    cdb(1, 32'h11, 1'b0);
    chk("no_early_commit", 64'(commit_valid), 64'd0);
    cdb(0, 32'h10, 1'b0);
    cdb(2, 32'h12, 1'b0);
    repeat (3) tick();
    chk("drain_count", 64'(count), 64'd0);

    // Full buffer, dropped dispatch, tag wrap
    pulse_reset();
    for (int i = 0; i < 32; i++) dispatch(1'b1, i, 1'b0);
    chk("full_count",      64'(count),      64'd32);
    chk("full_disp_ready", 64'(disp_ready), 64'd0);
    chk("full_disp_tag",   64'(disp_tag),   64'd0);
    dispatch(1'b1, 9, 1'b0);
    chk("drop_count", 64'(count), 64'd32);
    push(0, 1'b1, 0, 32'h100, 1'b0);
    cdb(0, 32'h100, 1'b0);
    chk("full_commit_cycle_ready", 64'(disp_ready), 64'd0);
    tick();
    chk("after_commit_count", 64'(count),      64'd31);
    chk("after_commit_ready", 64'(disp_ready), 64'd1);
    chk("wrap_tag",           64'(disp_tag),   64'd0);
    dispatch(1'b1, 7, 1'b0);
    chk("wrap_count", 64'(count),    64'd32);
    chk("wrap_tail",  64'(disp_tag), 64'd1);

    // Simultaneous commit and dispatch
    pulse_reset();
    for (int i = 0; i < 5; i++) dispatch(1'b1, i + 10, 1'b0);
    push(0, 1'b1, 10, 32'h50, 1'b0);
    cdb(0, 32'h50, 1'b0);
    chk("sim_pre_count", 64'(count), 64'd5);
    dispatch(1'b1, 20, 1'b0);
    chk("sim_count",  64'(count),        64'd5);
    chk("sim_tail",   64'(disp_tag),     64'd6);
    chk("sim_idle",   64'(commit_valid), 64'd0);

    // Mispredicted branch at tag 4 with younger entries in flight
    pulse_reset();
    for (int i = 0; i < 8; i++)
      dispatch(i != 4, (i == 4) ? 0 : i + 1, i == 4);
    for (int i = 0; i < 4; i++) push(i, 1'b1, i + 1, 32'h200 + i, 1'b0);
    push(4, 1'b0, 0, 0, 1'b1);
    for (int i = 0; i < 4; i++) cdb(i, 32'h200 + i, 1'b0);
    cdb(4, 0, 1'b1);
    chk("flush_high",  64'(flush), 64'd1);
    chk("flush_count", 64'(count), 64'd4);
    tick();
    chk("flush_pulse",    64'(flush),        64'd0);
    chk("post_flush_cnt", 64'(count),        64'd0);
    chk("post_flush_cv",  64'(commit_valid), 64'd0);
    chk("post_flush_tag", 64'(disp_tag),     64'd0);
    cdb(6, 32'h66, 1'b0);
    rd_tag = 5'd6;
    #1;
    chk("late_cdb_rd_ready", 64'(rd_ready),     64'd0);
    chk("late_cdb_cv",       64'(commit_valid), 64'd0);
    chk("late_cdb_count",    64'(count),        64'd0);

    // Operand lookup, no CDB bypass
    pulse_reset();
    for (int i = 0; i < 4; i++) dispatch(1'b1, i + 1, 1'b0);
    rd_tag = 5'd3;
    #1;
    chk("rd_before", 64'(rd_ready), 64'd0);
    cdb_valid = 1'b1; cdb_tag = 5'd3; cdb_data = 32'hABCD; cdb_mispredict = 1'b0;
    #1;
    chk("rd_no_bypass", 64'(rd_ready), 64'd0);
    tick();
    cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;
    chk("rd_after",      64'(rd_ready),     64'd1);
    chk("rd_data",       64'(rd_data),      64'hABCD);
    chk("rd_no_commit",  64'(commit_valid), 64'd0);

    // Reset while a commit is pending
    cdb(0, 32'h77, 1'b0);
    chk("pre_reset_cv", 64'(commit_valid), 64'd1);
    reset = 1'b1;
    #1;
    chk("async_rst_cv",       64'(commit_valid), 64'd0);
    chk("async_rst_count",    64'(count),        64'd0);
    chk("async_rst_rd_ready", 64'(rd_ready),     64'd0);
    chk("async_rst_rd_data",  64'(rd_data),      64'd0);
    tick();
    reset = 1'b0;
    repeat (3) tick();
    chk("scoreboard_drain", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
